// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM states, instruction width, default reset PC.
// Pure declarations; no timing or flow-control behaviour of its own.
package riscv_pkg;

  localparam int          ILEN             = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    SQUASH
  } fetch_state_t;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [31:0]     pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding slot for a fetched word that arrives while decode is stalled.
// Latency: push visible as full next cycle; flush beats push, push beats pop.
module fetch_skid
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_vld,
  input  fetch_pkt_t push_dat,
  input  logic       pop_rdy,
  input  logic       flush,
  output logic       full,
  output fetch_pkt_t pop_dat
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 1'b0;
      pop_dat <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push_vld) begin
      full    <= 1'b1;
      pop_dat <= push_dat;
    end else if (pop_rdy) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, skid-buffered output to decode (FETCH_MISALIGN_TRAP_EN adds misalign).
// Latency: accept N, rvalid N+1, if_valid N+2; stall holds if_* and parks one word in the skid buffer.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            branch,
  input  logic [31:0]     branch_target,
  input  logic            stall,
  output logic            if_valid,
  output logic [ILEN-1:0] if_instr,
  output logic [31:0]     if_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalign
`endif
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         accept;
  logic         rsp;
  logic         out_free;
  logic         skid_full;
  logic         skid_pop;
  fetch_pkt_t   skid_dat;
  fetch_pkt_t   rsp_pkt;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic bad_target;

  // A misaligned target is reported and otherwise ignored.
  assign bad_target  = branch && (branch_target[1:0] != 2'b00);
  assign redirect    = branch && !bad_target;
  assign redirect_pc = branch_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign <= 1'b0;
    else        misalign <= bad_target;
  end
`else
  assign redirect    = branch;
  assign redirect_pc = branch_target & 32'hFFFF_FFFC;
`endif

  assign imem_req  = (state == REQ) && !skid_full;
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;
  assign rsp       = (state == WAIT) && imem_rvalid && !redirect;
  assign out_free  = !if_valid || !stall;
  assign skid_pop  = skid_full && !stall && !redirect;
  assign rsp_pkt   = {imem_rdata, pc};

  fetch_skid u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (rsp && !out_free),
    .push_dat (rsp_pkt),
    .pop_rdy  (skid_pop),
    .flush    (redirect),
    .full     (skid_full),
    .pop_dat  (skid_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (redirect) begin
      if_valid <= 1'b0;
    end else if (skid_pop) begin
      if_valid <= 1'b1;
      if_instr <= skid_dat.instr;
      if_pc    <= skid_dat.pc;
    end else if (rsp && out_free) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc    <= pc;
    end else if (!stall) begin
      if_valid <= 1'b0;
    end
  end

  // A response coincident with a redirect completes the old request, so
  // SQUASH is only needed while that response is still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      if (redirect)  pc <= redirect_pc;
      else if (rsp)  pc <= pc + 32'd4;
      case (state)
        IDLE:    state <= REQ;
        REQ:     if (accept) state <= redirect ? SQUASH : WAIT;
        WAIT:    if (imem_rvalid) state <= REQ;
                 else if (redirect) state <= SQUASH;
        SQUASH:  if (imem_rvalid) state <= REQ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: program-order stream model plus directed scenarios.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        branch;
  logic [31:0] branch_target;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int tests = 0;
  int fails = 0;
  int mem_lat = 1;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .branch        (branch),
    .branch_target (branch_target),
    .stall         (stall),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign      (misalign)
`endif
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  // Waits at least one cycle, returns at the negedge where if_valid is seen.
  task automatic wait_valid(input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_valid && n < 60);
    if (!if_valid) chk1({nm, "_timeout"}, if_valid, 1'b1);
  endtask

  // Returns at the first negedge (possibly the current one) with an accepted request.
  task automatic wait_accept(input string nm, output logic [31:0] addr);
    int n;
    n = 0;
    while (!(imem_req && imem_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!(imem_req && imem_ready)) chk1({nm, "_timeout"}, imem_req && imem_ready, 1'b1);
    addr = imem_addr;
  endtask

  // Memory: answers each accepted request mem_lat cycles later with instr_of(addr).
  bit          mem_acc;
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_acc_a;
  logic [31:0] mem_a;
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    mem_busy    = 1'b0;
    mem_cnt     = 0;
    mem_a       = '0;
    forever begin
      @(negedge clk);
      mem_acc   = rst_n && imem_req && imem_ready;
      mem_acc_a = imem_addr;
      @(posedge clk);
      #2;
      imem_rvalid = 1'b0;
      if (mem_acc) begin
        mem_busy = 1'b1;
        mem_cnt  = mem_lat;
        mem_a    = mem_acc_a;
      end
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = instr_of(mem_a);
          mem_busy    = 1'b0;
        end
      end
    end
  end

  // Model: decode must see words in program order, restarting at each taken target.
  logic [31:0] exp_pc;
  bit          hold_q;
  bit          dut_out;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc  = RST_PC;
      hold_q  = 1'b0;
      dut_out = 1'b0;
    end else begin
      if (hold_q) chk1("hold_valid", if_valid, 1'b1);
      if (imem_req) chk1("one_outstanding", dut_out, 1'b0);
      if (if_valid) begin
        chk("stream_pc", if_pc, exp_pc);
        chk("stream_instr", if_instr, instr_of(exp_pc));
        if (!stall) exp_pc = exp_pc + 32'd4;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      if (branch && branch_target[1:0] == 2'b00) exp_pc = branch_target;
`else
      if (branch) exp_pc = {branch_target[31:2], 2'b00};
`endif
      if (imem_rvalid) dut_out = 1'b0;
      if (imem_req && imem_ready) dut_out = 1'b1;
      hold_q = if_valid && stall && !branch;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    logic [31:0] p;
    logic [31:0] a;
    rst_n         = 1'b0;
    imem_ready    = 1'b1;
    branch        = 1'b0;
    branch_target = '0;
    stall         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, RST_PC);
    chk1("rst_valid", if_valid, 1'b0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);

    // Reset release with zero-wait memory.
    @(posedge clk); #1 rst_n = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!if_valid && k < 10);
    chk("first_valid_cycles", k, 3);
    chk("beat0_pc", if_pc, 32'h0);
    chk("beat0_instr", if_instr, 32'h1357_6420);
    @(negedge clk);
    wait_valid("beat1", k);
    chk("beat1_pc", if_pc, 32'h4);
    chk("beat1_gap", k, 2);
    wait_valid("beat2", k);
    chk("beat2_pc", if_pc, 32'h8);
    chk("beat2_gap", k, 2);

    // Branch while waiting on a slow response.
    mem_lat = 3;
    wait_accept("t2_acc", a);
    @(posedge clk); #1 branch = 1'b1; branch_target = 32'h100;
    @(posedge clk); #1 branch = 1'b0;
    wait_valid("t2_valid", k);
    chk("t2_pc", if_pc, 32'h100);

    // Five stall cycles: output held, one word parked, no requests.
    mem_lat = 1;
    wait_valid("t3_pre", k);
    wait_accept("t3_acc", p);
    @(posedge clk); #1 stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk1("t3_valid", if_valid, 1'b1);
    chk("t3_held_pc", if_pc, p);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_pc", if_pc, p);
      chk1("t3_no_req", imem_req, 1'b0);
    end
    @(posedge clk); #1 stall = 1'b0;
    @(negedge clk);
    chk("t3_rel_pc", if_pc, p);
    @(negedge clk);
    chk("t3_skid_pc", if_pc, p + 32'd4);
    chk1("t3_req_after", imem_req, 1'b1);

    // PC wrap at the top of the address space.
    @(posedge clk); #1 branch = 1'b1; branch_target = 32'hFFFF_FFFC;
    @(posedge clk); #1 branch = 1'b0;
    wait_valid("t4_valid", k);
    chk("t4_pc", if_pc, 32'hFFFF_FFFC);
    wait_accept("t4_acc", a);
    chk("t4_wrap_addr", a, 32'h0000_0000);

    // Branch and stall together.
    @(posedge clk); #1 stall = 1'b1;
    wait_valid("t5_fill", k);
    @(posedge clk); #1 branch = 1'b1; branch_target = 32'h200;
    @(negedge clk);
    chk1("t5_valid_during", if_valid, 1'b1);
    @(posedge clk); #1 branch = 1'b0;
    @(negedge clk);
    chk1("t5_cleared", if_valid, 1'b0);
    wait_valid("t5_new", k);
    chk("t5_pc", if_pc, 32'h200);
    @(posedge clk); #1 stall = 1'b0;

    // Reset mid-WAIT: the late response must be ignored.
    mem_lat = 3;
    @(negedge clk);
    wait_accept("t6_acc", a);
    @(posedge clk); #1 rst_n = 1'b0; imem_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("t6_stale_ignored", if_valid, 1'b0);
    end
    chk("t6_addr", imem_addr, RST_PC);
    mem_lat = 1;
    @(posedge clk); #1 imem_ready = 1'b1;
    wait_valid("t6_valid", k);
    chk("t6_pc", if_pc, RST_PC);

    // Unaligned target with memory not ready.
    @(posedge clk); #1 imem_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("t7_addr_before", imem_addr, RST_PC + 32'd8);
`ifdef FETCH_MISALIGN_TRAP_EN
    @(posedge clk); #1 branch = 1'b1; branch_target = 32'h102;
    @(negedge clk);
    chk1("t7_misalign_pre", misalign, 1'b0);
    @(posedge clk); #1 branch = 1'b0;
    @(negedge clk);
    chk1("t7_misalign_pulse", misalign, 1'b1);
    chk("t7_pc_kept", imem_addr, RST_PC + 32'd8);
    @(negedge clk);
    chk1("t7_misalign_end", misalign, 1'b0);
    @(posedge clk); #1 imem_ready = 1'b1;
    wait_valid("t7_valid", k);
    chk("t7_pc", if_pc, RST_PC + 32'd8);
`else
    @(posedge clk); #1 branch = 1'b1; branch_target = 32'h302;
    @(posedge clk); #1 branch = 1'b0;
    @(negedge clk);
    chk("t7_aligned_addr", imem_addr, 32'h300);
    chk1("t7_req_kept", imem_req, 1'b1);
    @(posedge clk); #1 imem_ready = 1'b1;
    wait_valid("t7_valid", k);
    chk("t7_pc", if_pc, 32'h300);
`endif

    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
